// File: rtl/decode_stage.sv
// Buffered instruction decoder between fetch and execute: input FIFO, long-instruction
// assembler joining SPECIAL_LONG with its extension word, and a registered valid/ready output.
module decode_stage #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int REL_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           in_word,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_group,
  output logic [3:0]            out_operator,
  output logic [2:0]            out_rg1,
  output logic [2:0]            out_rg2,
  output logic [7:0]            out_val,
  output logic [7:0]            out_flags,
  output logic [REL_WIDTH-1:0]  out_rel,
  output logic                  out_long,
  output logic [15:0]           out_ext,
  output logic [ADDR_WIDTH-1:0] out_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] G_CRVMATH       = 4'd0;
  localparam logic [3:0] G_RJMP          = 4'd1;
  localparam logic [3:0] G_CRRMATH       = 4'd2;
  localparam logic [3:0] G_CRSMATH       = 4'd3;
  localparam logic [3:0] G_WRRMATH       = 4'd4;
  localparam logic [3:0] G_WRRMATH_MEM   = 4'd5;
  localparam logic [3:0] G_WRSMATH       = 4'd6;
  localparam logic [3:0] G_WRSMATH_STACK = 4'd7;
  localparam logic [3:0] G_SFLAG         = 4'd8;
  localparam logic [3:0] G_UFLAG         = 4'd9;
  localparam logic [3:0] G_SPECIAL       = 4'd10;
  localparam logic [3:0] G_SPECIAL_LONG  = 4'd11;

  typedef struct packed {
    logic [3:0]            grp;
    logic [3:0]            op;
    logic [2:0]            rg1;
    logic [2:0]            rg2;
    logic [7:0]            val;
    logic [7:0]            flags;
    logic [REL_WIDTH-1:0]  rel;
    logic                  lng;
    logic [15:0]           ext;
    logic [ADDR_WIDTH-1:0] pc;
  } dec_t;

  typedef enum logic {S_FIRST, S_EXT} st_t;

  function automatic logic [3:0] group_of(input logic [15:0] w);
    logic [3:0] g;
    if (!w[4])                 g = G_CRVMATH;
    else if (w[4:3] == 2'b10)  g = G_RJMP;
    else begin
      case (w[2:0])
        3'b100:  g = G_CRRMATH;
        3'b110:  g = G_CRSMATH;
        3'b101:  g = (w[15:12] == 4'b1011 || w[15:12] == 4'b1111) ? G_WRRMATH :
                     (w[15] ? G_WRRMATH_MEM : G_WRRMATH);
        3'b111:  g = (w[15:13] == 3'b111) ? G_WRSMATH_STACK : G_WRSMATH;
        3'b000:  g = G_SFLAG;
        3'b001:  g = G_UFLAG;
        3'b011:  g = (w[15:13] == 3'b111) ? G_SPECIAL_LONG : G_SPECIAL;
        default: g = G_SPECIAL;
      endcase
    end
    return g;
  endfunction

  logic [15:0]           mem_q [DEPTH];
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0] pc_q, hold_pc_q;
  logic [15:0]           hold_word_q;
  logic                  out_valid_q;
  dec_t                  out_q, dec_d;
  st_t                   st_q, st_d;
  logic                  full, empty, push, pop, ld, hold, can_load;
  logic [15:0]           head, src;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign in_ready = rst_n && !full && !flush;
  assign push     = in_valid && in_ready;
  assign can_load = !out_valid_q || out_ready;
  assign head     = mem_q[rd_q];

  // Assembler FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n || flush) st_q <= S_FIRST;
    else                 st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      S_FIRST: if (hold) st_d = S_EXT;
      S_EXT:   if (pop)  st_d = S_FIRST;
      default: st_d = S_FIRST;
    endcase
  end

  // A long first word is parked in the hold registers instead of loading the output.
  always_comb begin
    pop  = !empty && can_load;
    ld   = 1'b0;
    hold = 1'b0;
    if (pop) begin
      if (st_q == S_EXT)              ld   = 1'b1;
      else if (group_of(head) == G_SPECIAL_LONG) hold = 1'b1;
      else                            ld   = 1'b1;
    end
  end

  always_comb begin
    src         = (st_q == S_EXT) ? hold_word_q : head;
    dec_d.grp   = group_of(src);
    dec_d.op    = src[15:12];
    dec_d.rg1   = src[0] ? src[7:5] : src[3:1];
    dec_d.rg2   = src[10:8];
    dec_d.val   = src[11:4];
    dec_d.flags = src[15:8];
    dec_d.rel   = REL_WIDTH'($signed(src[7:0]));
    dec_d.lng   = (st_q == S_EXT);
    dec_d.ext   = (st_q == S_EXT) ? head : 16'h0;
    dec_d.pc    = (st_q == S_EXT) ? hold_pc_q : pc_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      pc_q        <= '0;
      hold_pc_q   <= '0;
      hold_word_q <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      pc_q        <= flush_pc;
      hold_pc_q   <= '0;
      hold_word_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (pop) pc_q <= pc_q + 1'b1;
      if (hold) begin
        hold_word_q <= head;
        hold_pc_q   <= pc_q;
      end
      if (ld) begin
        out_q       <= dec_d;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_group    = out_q.grp;
  assign out_operator = out_q.op;
  assign out_rg1      = out_q.rg1;
  assign out_rg2      = out_q.rg2;
  assign out_val      = out_q.val;
  assign out_flags    = out_q.flags;
  assign out_rel      = out_q.rel;
  assign out_long     = out_q.lng;
  assign out_ext      = out_q.ext;
  assign out_pc       = out_q.pc;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference decoder/assembler predicts each output
// when a word is accepted; a negedge monitor compares every output transfer in order.
module tb_decode_stage;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int RW    = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   in_word = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic [AW-1:0] flush_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_group, out_operator;
  logic [2:0]    out_rg1, out_rg2;
  logic [7:0]    out_val, out_flags;
  logic [RW-1:0] out_rel;
  logic          out_long;
  logic [15:0]   out_ext;
  logic [AW-1:0] out_pc;

  decode_stage #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .REL_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .flush_pc(flush_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_group(out_group), .out_operator(out_operator), .out_rg1(out_rg1), .out_rg2(out_rg2),
    .out_val(out_val), .out_flags(out_flags), .out_rel(out_rel), .out_long(out_long),
    .out_ext(out_ext), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [95:0] sb [$];
  int xfer_cyc [$];
  logic [AW-1:0] mpc = '0, mpcs = '0;
  logic [15:0]   mword = '0;
  bit            mpend = 1'b0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] grp(input logic [15:0] w);
    logic [4:0] s;
    s = w[4:0];
    if (s[4] == 1'b0)      return 4'd0;
    if (s[4:3] == 2'b10)   return 4'd1;
    case (s)
      5'b11100: return 4'd2;
      5'b11110: return 4'd3;
      5'b11101: begin
        if (w[15:12] == 4'b1011 || w[15:12] == 4'b1111) return 4'd4;
        if (w[15]) return 4'd5;
        return 4'd4;
      end
      5'b11111: return (w[15:13] == 3'b111) ? 4'd7 : 4'd6;
      5'b11000: return 4'd8;
      5'b11001: return 4'd9;
      5'b11011: return (w[15:13] == 3'b111) ? 4'd11 : 4'd10;
      default:  return 4'd10;
    endcase
  endfunction

  function automatic logic [95:0] model(input logic [15:0] w, input logic lng,
                                        input logic [15:0] ext, input logic [AW-1:0] pc);
    logic [RW-1:0] rel;
    logic [2:0] r1;
    rel = {{(RW-8){w[7]}}, w[7:0]};
    r1  = w[0] ? w[7:5] : w[3:1];
    return 96'({grp(w), w[15:12], r1, w[10:8], w[11:4], w[15:8], rel, lng, ext, pc});
  endfunction

  function automatic logic [95:0] obs();
    return 96'({out_group, out_operator, out_rg1, out_rg2, out_val, out_flags, out_rel,
                out_long, out_ext, out_pc});
  endfunction

  always @(posedge clk) cyc++;

  // Monitor/model: transfers and acceptances that will happen at the coming posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete(); mpc = '0; mpend = 1'b0;
    end else if (flush) begin
      sb.delete(); mpc = flush_pc; mpend = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        xfer_cyc.push_back(cyc);
        if (sb.size() == 0) chk("unexpected_out", obs(), 96'hx);
        else chk("out", obs(), sb.pop_front());
      end
      if (in_valid && in_ready) begin
        if (mpend) begin
          sb.push_back(model(mword, 1'b1, in_word, mpcs));
          mpend = 1'b0;
        end else if (grp(in_word) == 4'd11) begin
          mpend = 1'b1; mword = in_word; mpcs = mpc;
        end else begin
          sb.push_back(model(in_word, 1'b0, 16'h0, mpc));
        end
        mpc = mpc + 1'b1;
      end
    end
  end

  task automatic offer(input logic [15:0] w, input int lim, output bit ok);
    bit r;
    ok = 1'b0;
    in_valid = 1'b1; in_word = w;
    for (int t = 0; t < lim; t++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] w);
    bit ok;
    offer(w, 100, ok);
    if (!ok) chk("send_timeout", 96'(ok), 96'(1));
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !out_valid) begin done = 1'b1; break; end
    end
    chk("drain", 96'(done), 96'(1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit ok;
    int acc, nx;
    // reset state
    @(posedge clk); #1;
    chk("rst_in_ready", 96'(in_ready), 96'(0));
    chk("rst_out_valid", 96'(out_valid), 96'(0));
    chk("rst_fields", obs(), 96'(0));
    do_reset();

    // 1: short words, latency and throughput
    out_ready = 1'b1;
    xfer_cyc.delete();
    send(16'h1234);
    chk("lat_edge1", 96'(out_valid), 96'(0));
    send(16'h0008);
    chk("lat_edge2", 96'(out_valid), 96'(1));
    send(16'h0005);
    drain();
    chk("t1_count", 96'(xfer_cyc.size()), 96'(3));
    if (xfer_cyc.size() == 3) begin
      chk("t1_gap0", 96'(xfer_cyc[1] - xfer_cyc[0]), 96'(1));
      chk("t1_gap1", 96'(xfer_cyc[2] - xfer_cyc[1]), 96'(1));
    end

    // 2: long instruction, then delayed extension
    do_reset();
    send(16'hE01B); send(16'hBEEF); send(16'h0008);
    drain();
    do_reset();
    send(16'hE01B);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("ext_wait", 96'(out_valid), 96'(0));
    end
    send(16'hBEEF);
    drain();

    // 3: wide group classification
    send(16'hB01D); send(16'h901D); send(16'h301D); send(16'hE01F); send(16'h201F);
    drain();

    // 4: backpressure fills FIFO plus output register
    do_reset();
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      offer(16'h1102 + 16'(i) * 16'h1010, 3, ok);
      if (ok) acc++;
    end
    chk("bp_accepted", 96'(acc), 96'(DEPTH + 1));
    chk("bp_in_ready", 96'(in_ready), 96'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("bp_valid", 96'(out_valid), 96'(1));
      if (sb.size() > 0) chk("bp_stable", obs(), sb[0]);
    end
    nx = xfer_cyc.size();
    out_ready = 1'b1;
    drain();
    chk("bp_drained", 96'(xfer_cyc.size() - nx), 96'(DEPTH + 1));

    // 5: flush while waiting for extension, then PC wrap
    do_reset();
    send(16'hE01B);
    flush = 1'b1; flush_pc = 16'h0100;
    #1 chk("flush_in_ready", 96'(in_ready), 96'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_out_valid", 96'(out_valid), 96'(0));
    send(16'h0002);
    drain();
    flush = 1'b1; flush_pc = 16'hFFFF;
    @(posedge clk); #1;
    flush = 1'b0;
    send(16'h0006); send(16'h0004);
    drain();

    // 6: reset mid-stream
    do_reset();
    out_ready = 1'b0;
    send(16'h0002); send(16'h0004); send(16'h0006);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", 96'(out_valid), 96'(0));
    chk("mid_rst_ready", 96'(in_ready), 96'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      chk("rst_stale", 96'(out_valid), 96'(0));
    end
    send(16'h0003);
    drain();
    chk("sb_empty", 96'(sb.size()), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
